// File: rtl/lab7soc_gpx_pkg.sv
// lab7soc_gpx_pkg: register offsets, edge-select encodings and bit indices for the GPX event controller
package lab7soc_gpx_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd4;
  localparam logic [2:0] ADDR_EVCOUNT  = 3'd5;
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  localparam int CTRL_DB_EN = 0;
  localparam int EC_EVENT   = 0;
  localparam int EC_OVR     = 1;
endpackage

// File: rtl/gpx_debouncer.sv
// gpx_debouncer: two-flop synchroniser plus stability-count debouncer for the GPX pin
module gpx_debouncer #(
  parameter int DBW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_port,
  input  logic           db_en,
  input  logic [DBW-1:0] debounce,
  input  logic           clr,
  output logic           sync,
  output logic           deb_level
);
  logic sync1, sync_d;
  logic [DBW-1:0] stab_cnt;
  logic bypass;
  assign bypass = !db_en || debounce == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync      <= 1'b0;
      sync_d    <= 1'b0;
      deb_level <= 1'b0;
      stab_cnt  <= '0;
    end else begin
      sync1  <= in_port;
      sync   <= sync1;
      sync_d <= sync;
      if (bypass) begin
        deb_level <= sync;
        stab_cnt  <= '0;
      end else if (clr || sync == deb_level || sync != sync_d)
        stab_cnt <= '0;
      else if (stab_cnt + DBW'(1) == debounce) begin
        deb_level <= sync;
        stab_cnt  <= '0;
      end else
        stab_cnt <= stab_cnt + DBW'(1);
    end
endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// usb_gpx_event_ctrl: Avalon-MM slave turning the debounced GPX pin into captured edges, a counter and an irq
module usb_gpx_event_ctrl
  import lab7soc_gpx_pkg::*;
#(
  parameter int DBW = 16,
  parameter int CNT_W = 16,
  parameter logic [DBW-1:0] DB_RESET = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        in_port,
  output logic [31:0] readdata,
  output logic        irq
);
  logic [2:0] ctrl;
  logic mask;
  logic [1:0] edgecap;
  logic [DBW-1:0] debounce;
  logic [CNT_W-1:0] evcount;
  logic sync, deb_level, deb_d, ev, wr, unused;
  logic [1:0] w1c, edgecap_nx;
  logic [31:0] rd_mux;
  assign unused = ^{read, writedata};
  assign wr = chipselect && write;
  gpx_debouncer #(.DBW(DBW)) u_deb (
    .clk(clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .db_en(ctrl[CTRL_DB_EN]),
    .debounce(debounce),
    .clr(wr && (address == ADDR_CTRL || address == ADDR_DEBOUNCE)),
    .sync(sync),
    .deb_level(deb_level)
  );
  assign ev = (deb_level && !deb_d && ctrl[1]) || (!deb_level && deb_d && ctrl[2]);
  assign w1c = wr && address == ADDR_EDGECAP ? writedata[1:0] : 2'b00;
  // overrun looks at the pre-clear event bit; a new event always wins over the clear
  assign edgecap_nx = {(ev && edgecap[EC_EVENT]) || (edgecap[EC_OVR] && !w1c[EC_OVR]),
                       ev || (edgecap[EC_EVENT] && !w1c[EC_EVENT])};
  always_comb
    rd_mux = address == ADDR_DATA     ? {30'd0, sync, deb_level} :
             address == ADDR_CTRL     ? {29'd0, ctrl} :
             address == ADDR_IRQMASK  ? {31'd0, mask} :
             address == ADDR_EDGECAP  ? {30'd0, edgecap} :
             address == ADDR_DEBOUNCE ? 32'(debounce) :
             address == ADDR_EVCOUNT  ? 32'(evcount) : 32'd0;
  assign irq = edgecap[EC_EVENT] && mask;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl     <= 3'd0;
      mask     <= 1'b0;
      edgecap  <= 2'b00;
      debounce <= DB_RESET;
      evcount  <= '0;
      deb_d    <= 1'b0;
      readdata <= 32'd0;
    end else begin
      deb_d    <= deb_level;
      readdata <= rd_mux;
      edgecap  <= edgecap_nx;
      if (wr && address == ADDR_CTRL) ctrl <= writedata[2:0];
      if (wr && address == ADDR_IRQMASK) mask <= writedata[0];
      if (wr && address == ADDR_DEBOUNCE) debounce <= writedata[DBW-1:0];
      if (wr && address == ADDR_EVCOUNT) evcount <= ev ? CNT_W'(1) : '0;
      else if (ev && evcount != '1) evcount <= evcount + CNT_W'(1);
    end
endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// tb_usb_gpx_event_ctrl: directed register-level checks of the GPX event controller
module tb_usb_gpx_event_ctrl;
  logic clk = 1'b0;
  logic reset_n, chipselect, read, write, in_port, irq;
  logic [2:0] address;
  logic [31:0] writedata, readdata, rd;
  int checks = 0, errors = 0;
  usb_gpx_event_ctrl #(.DBW(16), .CNT_W(4), .DB_RESET(16'd0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask
  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask
  task automatic pin(input logic v, input int n);
    in_port = v;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0; in_port = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 3'd0; writedata = 32'd0;
    repeat (4) @(negedge clk);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rd_reg(3'd3, rd); chk("reset_edgecap", rd, 32'd0);
    // bypass path, rising edges only
    wr_reg(3'd4, 32'd0);
    wr_reg(3'd1, 32'd3);
    pin(1'b0, 6);
    in_port = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd_reg(3'd0, rd); chk("bypass_data", rd, 32'd3);
    rd_reg(3'd3, rd); chk("bypass_edgecap", rd, 32'd1);
    rd_reg(3'd5, rd); chk("bypass_evcount", rd, 32'd1);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    // irq and write-1-to-clear
    wr_reg(3'd2, 32'd1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr_reg(3'd3, 32'd1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    pin(1'b0, 6); pin(1'b1, 6); pin(1'b0, 6); pin(1'b1, 6);
    rd_reg(3'd3, rd); chk("overrun_edgecap", rd, 32'd3);
    rd_reg(3'd5, rd); chk("two_more_evcount", rd, 32'd3);
    wr_reg(3'd3, 32'd3);
    rd_reg(3'd3, rd); chk("edgecap_cleared", rd, 32'd0);
    // debounced glitch rejection, both edges
    wr_reg(3'd4, 32'hABCD_0004);
    rd_reg(3'd4, rd); chk("debounce_rb", rd, 32'd4);
    wr_reg(3'd1, 32'd7);
    rd_reg(3'd1, rd); chk("ctrl_rb", rd, 32'd7);
    in_port = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pin(1'b1, 10);
    rd_reg(3'd3, rd); chk("glitch_edgecap", rd, 32'd0);
    rd_reg(3'd0, rd); chk("glitch_data", rd, 32'd3);
    pin(1'b0, 12);
    rd_reg(3'd0, rd); chk("stable_data", rd, 32'd0);
    rd_reg(3'd3, rd); chk("stable_edgecap", rd, 32'd1);
    // collisions of event with W1C and EVCOUNT clear
    wr_reg(3'd3, 32'd3);
    wr_reg(3'd4, 32'd0);
    wr_reg(3'd1, 32'd3);
    pin(1'b1, 6); pin(1'b0, 6);
    in_port = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_reg(3'd3, 32'd1);
    rd_reg(3'd3, rd); chk("collide_edgecap", rd, 32'd3);
    chk("collide_irq", {31'd0, irq}, 32'd1);
    pin(1'b0, 6);
    in_port = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_reg(3'd5, 32'd0);
    rd_reg(3'd5, rd); chk("collide_evcount", rd, 32'd1);
    // saturation with both edges in bypass
    wr_reg(3'd1, 32'd7);
    wr_reg(3'd5, 32'd0);
    for (int i = 1; i <= 17; i++) begin
      pin(~in_port, 4);
      if (i == 14) begin
        rd_reg(3'd5, rd); chk("evcount_14", rd, 32'd14);
      end
    end
    rd_reg(3'd5, rd); chk("evcount_sat", rd, 32'd15);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    rd_reg(3'd6, rd); chk("reserved6", rd, 32'd0);
    rd_reg(3'd7, rd); chk("reserved7", rd, 32'd0);
    rd_reg(3'd1, rd); chk("ctrl_after_rsvd_wr", rd, 32'd7);
    // reset in mid-operation
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midrst_readdata", readdata, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rd_reg(3'd5, rd); chk("midrst_evcount", rd, 32'd0);
    rd_reg(3'd3, rd); chk("midrst_edgecap", rd, 32'd0);
    rd_reg(3'd4, rd); chk("midrst_debounce", rd, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
